// File: rtl/vc_sys_pkg.sv
// Shared types for the vc reset/boot sequencer: sequencer states and
// the reset-cause encoding reported to software.
package vc_sys_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    INVAL = 2'd1,
    STAGE = 2'd2,
    RUN   = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_EXT  = 2'd0;
  localparam logic [1:0] CAUSE_ENA  = 2'd1;
  localparam logic [1:0] CAUSE_SOFT = 2'd2;
  localparam logic [1:0] CAUSE_WDOG = 2'd3;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vc_reset_wdog.sv
// Watchdog for the reset sequencer (built only with VC_RESET_WDOG_EN):
// counts while the sequencer is in RUN and flags expiry at all-ones.
module vc_reset_wdog #(
  parameter int WDOG_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic kick_i,
  output logic expire_o
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  // A kick in the expiry cycle wins: it both clears and masks the pulse.
  always_comb begin
    cnt_d = '0;
    if (run_i && !kick_i) cnt_d = cnt_q + WDOG_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = run_i && !kick_i && (&cnt_q);

endmodule

// File: rtl/vc_reset_seq.sv
// Reset/boot sequencer for the vc core: stretch, invalidate sweep, ordered
// domain release, strap capture. VC_RESET_WDOG_EN adds a RUN-state watchdog.
module vc_reset_seq
  import vc_sys_pkg::*;
#(
  parameter int NDOM      = 3,
  parameter int STRETCH   = 16,
  parameter int STAGE_GAP = 4,
  parameter int NLINES    = 16,
  parameter int STRAP_W   = 4,
  parameter int WDOG_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ena,
  input  logic [STRAP_W-1:0]        strap_in,
  input  logic                      sw_reset_req,
  input  logic                      wdog_kick,
  input  logic                      inv_ready,
  output logic                      inv_valid,
  output logic [$clog2(NLINES)-1:0] inv_index,
  output logic [NDOM-1:0]           dom_reset,
  output logic [STRAP_W-1:0]        strap_q,
  output logic                      boot_done,
  output logic [1:0]                reset_cause
);

  localparam int IDX_W   = $clog2(NLINES);
  localparam int CNT_MAX = imax(STRETCH - 1, (NDOM - 1) * STAGE_GAP + 1);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 inv_valid_q, inv_valid_d;
  logic [IDX_W-1:0]     inv_index_q, inv_index_d;
  logic [NDOM-1:0]      dom_reset_q, dom_reset_d;
  logic [STRAP_W-1:0]   strap_lat_q, strap_lat_d;
  logic                 boot_done_q, boot_done_d;
  logic [1:0]           cause_q, cause_d;
  logic                 go_hold;
  logic                 wdog_expire;
  logic [NDOM-1:0]      rel_hit;

`ifdef VC_RESET_WDOG_EN
  vc_reset_wdog #(
    .WDOG_W (WDOG_W)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .run_i    (state_q == RUN),
    .kick_i   (wdog_kick),
    .expire_o (wdog_expire)
  );
`else
  localparam int unused_wdog_w = WDOG_W;
  logic unused_kick;
  assign unused_kick = wdog_kick;
  assign wdog_expire = 1'b0;
`endif

  // Domain i is released on the STAGE count i*STAGE_GAP; since the count only
  // climbs, lower-indexed domains always drop first.
  for (genvar i = 0; i < NDOM; i++) begin : g_rel
    assign rel_hit[i] = (cnt_q == CNT_W'(i * STAGE_GAP));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    inv_valid_d = inv_valid_q;
    inv_index_d = inv_index_q;
    dom_reset_d = dom_reset_q;
    strap_lat_d = strap_lat_q;
    boot_done_d = boot_done_q;
    cause_d     = cause_q;
    go_hold     = 1'b0;

    if (!ena) begin
      go_hold = 1'b1;
      // Only log on entry so a long-held-low ena keeps the first cause.
      if (state_q != HOLD) cause_d = CAUSE_ENA;
    end else if (wdog_expire) begin
      go_hold = 1'b1;
      cause_d = CAUSE_WDOG;
    end else if (state_q == RUN && sw_reset_req) begin
      go_hold = 1'b1;
      cause_d = CAUSE_SOFT;
    end

    if (go_hold) begin
      state_d     = HOLD;
      cnt_d       = '0;
      dom_reset_d = '1;
      inv_valid_d = 1'b0;
      inv_index_d = '0;
      boot_done_d = 1'b0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (cnt_q == CNT_W'(STRETCH - 1)) begin
            state_d     = INVAL;
            cnt_d       = '0;
            strap_lat_d = strap_in;
            inv_valid_d = 1'b1;
            inv_index_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        INVAL: begin
          if (inv_valid_q && inv_ready) begin
            if (inv_index_q == IDX_W'(NLINES - 1)) begin
              state_d     = STAGE;
              cnt_d       = '0;
              inv_valid_d = 1'b0;
              inv_index_d = '0;
            end else begin
              inv_index_d = inv_index_q + IDX_W'(1);
            end
          end
        end
        STAGE: begin
          cnt_d       = cnt_q + CNT_W'(1);
          dom_reset_d = dom_reset_q & ~rel_hit;
          if (!dom_reset_q[NDOM-1]) begin
            state_d     = RUN;
            boot_done_d = 1'b1;
          end
        end
        RUN: ;
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      inv_valid_q <= 1'b0;
      inv_index_q <= '0;
      dom_reset_q <= '1;
      strap_lat_q <= '0;
      boot_done_q <= 1'b0;
      cause_q     <= CAUSE_EXT;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inv_valid_q <= inv_valid_d;
      inv_index_q <= inv_index_d;
      dom_reset_q <= dom_reset_d;
      strap_lat_q <= strap_lat_d;
      boot_done_q <= boot_done_d;
      cause_q     <= cause_d;
    end
  end

  assign inv_valid   = inv_valid_q;
  assign inv_index   = inv_index_q;
  assign dom_reset   = dom_reset_q;
  assign strap_q     = strap_lat_q;
  assign boot_done   = boot_done_q;
  assign reset_cause = cause_q;

endmodule

// File: tb/tb_vc_reset_seq.sv
// Directed bench for vc_reset_seq; cycle n is observed after n clock edges
// following reset release (cycle 0 shows the reset values).
module tb_vc_reset_seq;

  logic       clk = 1'b0;
  logic       reset, ena, sw_reset_req, wdog_kick, inv_ready;
  logic [3:0] strap_in;
  logic       inv_valid, boot_done;
  logic [3:0] inv_index;
  logic [2:0] dom_reset;
  logic [3:0] strap_q;
  logic [1:0] reset_cause;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  vc_reset_seq #(
    .NDOM(3), .STRETCH(16), .STAGE_GAP(4), .NLINES(16), .STRAP_W(4), .WDOG_W(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ena          (ena),
    .strap_in     (strap_in),
    .sw_reset_req (sw_reset_req),
    .wdog_kick    (wdog_kick),
    .inv_ready    (inv_ready),
    .inv_valid    (inv_valid),
    .inv_index    (inv_index),
    .dom_reset    (dom_reset),
    .strap_q      (strap_q),
    .boot_done    (boot_done),
    .reset_cause  (reset_cause)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic goto(input int c);
    if (c > cyc) step(c - cyc);
  endtask

  task automatic do_reset();
    reset = 1'b1; ena = 1'b1; inv_ready = 1'b1;
    sw_reset_req = 1'b0; wdog_kick = 1'b0; strap_in = 4'h0;
    step(2);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dom_reset !== 3'b111) begin errors++; $display("FAIL rst_dom: got %b want 111", dom_reset); end
    checks++; if (inv_valid !== 1'b0) begin errors++; $display("FAIL rst_inv_valid: got %b want 0", inv_valid); end
    checks++; if (inv_index !== 4'd0) begin errors++; $display("FAIL rst_inv_index: got %0d want 0", inv_index); end
    checks++; if (boot_done !== 1'b0) begin errors++; $display("FAIL rst_boot_done: got %b want 0", boot_done); end
    checks++; if (strap_q !== 4'h0) begin errors++; $display("FAIL rst_strap: got %h want 0", strap_q); end
    checks++; if (reset_cause !== 2'd0) begin errors++; $display("FAIL rst_cause: got %0d want 0", reset_cause); end
  endtask

  task automatic test_clean_boot();
    do_reset();
    goto(15);
    checks++; if (inv_valid !== 1'b0 || dom_reset !== 3'b111) begin errors++; $display("FAIL boot_hold15: valid=%b dom=%b want 0/111", inv_valid, dom_reset); end
    for (int c = 16; c < 32; c++) begin
      goto(c);
      checks++;
      if (inv_valid !== 1'b1 || inv_index !== 4'(c - 16)) begin
        errors++; $display("FAIL boot_sweep c%0d: valid=%b idx=%0d want 1/%0d", c, inv_valid, inv_index, c - 16);
      end
    end
    goto(32);
    checks++; if (inv_valid !== 1'b0 || dom_reset !== 3'b111) begin errors++; $display("FAIL boot_c32: valid=%b dom=%b want 0/111", inv_valid, dom_reset); end
    goto(33);
    checks++; if (dom_reset !== 3'b110) begin errors++; $display("FAIL boot_c33: dom=%b want 110", dom_reset); end
    goto(36);
    checks++; if (dom_reset !== 3'b110) begin errors++; $display("FAIL boot_c36: dom=%b want 110", dom_reset); end
    goto(37);
    checks++; if (dom_reset !== 3'b100) begin errors++; $display("FAIL boot_c37: dom=%b want 100", dom_reset); end
    goto(40);
    checks++; if (dom_reset !== 3'b100) begin errors++; $display("FAIL boot_c40: dom=%b want 100", dom_reset); end
    goto(41);
    checks++; if (dom_reset !== 3'b000 || boot_done !== 1'b0) begin errors++; $display("FAIL boot_c41: dom=%b done=%b want 000/0", dom_reset, boot_done); end
    goto(42);
    checks++; if (boot_done !== 1'b1) begin errors++; $display("FAIL boot_c42: done=%b want 1", boot_done); end
    checks++; if (reset_cause !== 2'd0) begin errors++; $display("FAIL boot_cause: got %0d want 0", reset_cause); end
  endtask

  task automatic test_stall();
    do_reset();
    goto(23);
    inv_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      checks++;
      if (inv_valid !== 1'b1 || inv_index !== 4'd7) begin
        errors++; $display("FAIL stall_hold k%0d: valid=%b idx=%0d want 1/7", k, inv_valid, inv_index);
      end
    end
    inv_ready = 1'b1;
    step(1);
    checks++; if (inv_index !== 4'd8) begin errors++; $display("FAIL stall_resume: idx=%0d want 8", inv_index); end
    goto(46);
    checks++; if (boot_done !== 1'b0) begin errors++; $display("FAIL stall_c46: done=%b want 0", boot_done); end
    goto(47);
    checks++; if (boot_done !== 1'b1) begin errors++; $display("FAIL stall_c47: done=%b want 1", boot_done); end
  endtask

  task automatic test_ena_drop();
    do_reset();
    goto(35);
    ena = 1'b0;
    step(1);
    checks++; if (dom_reset !== 3'b111) begin errors++; $display("FAIL ena_dom: got %b want 111", dom_reset); end
    checks++; if (reset_cause !== 2'd1) begin errors++; $display("FAIL ena_cause: got %0d want 1", reset_cause); end
    step(2);
    ena = 1'b1;
    // ena is high for edges 38 onward, so this is cycle 0 of a fresh boot.
    goto(38 + 16);
    checks++; if (inv_valid !== 1'b1 || inv_index !== 4'd0) begin errors++; $display("FAIL ena_resweep: valid=%b idx=%0d want 1/0", inv_valid, inv_index); end
    goto(38 + 41);
    checks++; if (boot_done !== 1'b0) begin errors++; $display("FAIL ena_early: done=%b want 0", boot_done); end
    goto(38 + 42);
    checks++; if (boot_done !== 1'b1 || reset_cause !== 2'd1) begin errors++; $display("FAIL ena_reboot: done=%b cause=%0d want 1/1", boot_done, reset_cause); end
  endtask

  task automatic test_soft_reset();
    do_reset();
    goto(15);
    strap_in = 4'hA;
    step(1);
    strap_in = 4'h5;
    checks++; if (strap_q !== 4'hA) begin errors++; $display("FAIL soft_strap_a: got %h want a", strap_q); end
    goto(45);
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    checks++; if (dom_reset !== 3'b111 || boot_done !== 1'b0) begin errors++; $display("FAIL soft_dom: dom=%b done=%b want 111/0", dom_reset, boot_done); end
    checks++; if (reset_cause !== 2'd2) begin errors++; $display("FAIL soft_cause: got %0d want 2", reset_cause); end
    checks++; if (strap_q !== 4'hA) begin errors++; $display("FAIL soft_strap_keep: got %h want a", strap_q); end
    goto(46 + 15);
    checks++; if (strap_q !== 4'hA) begin errors++; $display("FAIL soft_strap_pre: got %h want a", strap_q); end
    goto(46 + 16);
    checks++; if (strap_q !== 4'h5) begin errors++; $display("FAIL soft_strap_5: got %h want 5", strap_q); end
    goto(46 + 42);
    checks++; if (boot_done !== 1'b1 || reset_cause !== 2'd2) begin errors++; $display("FAIL soft_reboot: done=%b cause=%0d want 1/2", boot_done, reset_cause); end
  endtask

  // Continues from the RUN state left by test_soft_reset (cause=2, strap=5).
  task automatic test_inval_req_and_reset();
    int base;
    goto(cyc + 2);
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    base = cyc;
    goto(base + 20);
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    checks++; if (inv_valid !== 1'b1 || inv_index !== 4'd5) begin errors++; $display("FAIL inval_ignore: valid=%b idx=%0d want 1/5", inv_valid, inv_index); end
    checks++; if (dom_reset !== 3'b111 || reset_cause !== 2'd2) begin errors++; $display("FAIL inval_state: dom=%b cause=%0d want 111/2", dom_reset, reset_cause); end
    goto(base + 35);
    checks++; if (dom_reset !== 3'b110) begin errors++; $display("FAIL midstage_pre: dom=%b want 110", dom_reset); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++; if (dom_reset !== 3'b111 || inv_valid !== 1'b0 || inv_index !== 4'd0) begin errors++; $display("FAIL midstage_rst: dom=%b valid=%b idx=%0d want 111/0/0", dom_reset, inv_valid, inv_index); end
    checks++; if (boot_done !== 1'b0 || strap_q !== 4'h0 || reset_cause !== 2'd0) begin errors++; $display("FAIL midstage_regs: done=%b strap=%h cause=%0d want 0/0/0", boot_done, strap_q, reset_cause); end
  endtask

`ifdef VC_RESET_WDOG_EN
  task automatic test_wdog();
    do_reset();
    goto(57);
    checks++; if (boot_done !== 1'b1) begin errors++; $display("FAIL wdog_pre: done=%b want 1", boot_done); end
    goto(58);
    checks++; if (boot_done !== 1'b0 || dom_reset !== 3'b111) begin errors++; $display("FAIL wdog_fire: done=%b dom=%b want 0/111", boot_done, dom_reset); end
    checks++; if (reset_cause !== 2'd3) begin errors++; $display("FAIL wdog_cause: got %0d want 3", reset_cause); end
    do_reset();
    for (int k = 0; k < 8; k++) begin
      goto(47 + 10 * k);
      wdog_kick = 1'b1;
      step(1);
      wdog_kick = 1'b0;
    end
    goto(130);
    checks++; if (boot_done !== 1'b1 || reset_cause !== 2'd0) begin errors++; $display("FAIL wdog_kicked: done=%b cause=%0d want 1/0", boot_done, reset_cause); end
  endtask
`else
  task automatic test_no_wdog();
    do_reset();
    goto(100);
    checks++; if (boot_done !== 1'b1 || reset_cause !== 2'd0) begin errors++; $display("FAIL nowdog_run: done=%b cause=%0d want 1/0", boot_done, reset_cause); end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_boot();
    test_stall();
    test_ena_drop();
    test_soft_reset();
    test_inval_req_and_reset();
`ifdef VC_RESET_WDOG_EN
    test_wdog();
`else
    test_no_wdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
